// File: rtl/periph_apb_pkg.sv
// Shared definitions for the APB register-access master: FSM encoding,
// peripheral control-register map and the slaves' reset defaults.
package periph_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam logic [31:0] CTL_OFF   = 32'h0;
  localparam logic [31:0] INTEN_OFF = 32'h4;
  localparam logic [31:0] STAT_OFF  = 32'h8;

  localparam logic [31:0] CTL_RST   = 32'h0000_002C;
  localparam logic [31:0] INTEN_RST = 32'h0000_FACE;
  localparam logic [31:0] STAT_RST  = 32'hF000_DA7A;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and wraps
// mod NREQ; returns a one-hot grant plus the encoded winner index.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  int   cand;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr_i) + k) % NREQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// Multi-requester APB master: round-robin accept in IDLE, then one
// SETUP/ACCESS transfer with optional pready timeout and a 1-cycle response pulse.
module apb_master_arb
  import periph_apb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               prstn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  output logic               pwrite,
  output logic               psel,
  output logic               penable,
  input  logic [DW-1:0]      prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  apb_state_e      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, idx_q, idx_d, gnt_idx;
  logic [NREQ-1:0] gnt, rsp_valid_q, rsp_valid_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic            pwrite_q, pwrite_d, err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign req_ready = (state_q == ST_IDLE) ? gnt : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_ready) begin
          idx_d    = gnt_idx;
          paddr_d  = req_addr[gnt_idx*AW +: AW];
          pwdata_d = req_wdata[gnt_idx*DW +: DW];
          pwrite_d = req_write[gnt_idx];
          ptr_d    = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready wins over a timeout landing on the same edge
        if (pready) begin
          rdata_d            = pwrite_q ? '0 : prdata;
          err_d              = pslverr;
          rsp_valid_d[idx_q] = 1'b1;
          cnt_d              = '0;
          state_d            = ST_IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          rdata_d            = '0;
          err_d              = 1'b1;
          rsp_valid_d[idx_q] = 1'b1;
          cnt_d              = '0;
          state_d            = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign psel      = (state_q != ST_IDLE);
  assign penable   = (state_q == ST_ACCESS);
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: two clients, small register-slave model,
// table of single transfers plus RR, wait-state, timeout and reset sequences.
module tb_apb_master_arb;
  import periph_apb_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TMO  = 4;

  logic            pclk, prstn;
  logic [NREQ-1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, pwdata, prdata;
  logic [AW-1:0]   paddr;
  logic            rsp_err, pwrite, psel, penable, pready, pslverr;

  int ncmp = 0;
  int nfail = 0;

  apb_master_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .prstn(prstn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // read-only register slave holding reset defaults; unmapped offsets error
  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    case (paddr)
      CTL_OFF:   prdata = CTL_RST;
      INTEN_OFF: prdata = INTEN_RST;
      STAT_OFF:  prdata = STAT_RST;
      default:   pslverr = psel & penable;
    endcase
  end

  typedef struct {
    int          c;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int c, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_valid[c]          = 1'b1;
    req_write[c]          = wr;
    req_addr[c*AW +: AW]  = a;
    req_wdata[c*DW +: DW] = d;
  endtask

  // Called at a negedge of an IDLE cycle with client c's request visible.
  // Returns at the negedge of the completion cycle.
  task automatic expect_xfer(input int c, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input int waits, input logic to,
                             input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[c] = 1'b1;
    n = to ? TMO : waits + 1;
    chk("req_ready", 64'(req_ready), 64'(oh));
    @(posedge pclk); #1;
    req_valid[c] = 1'b0;
    @(negedge pclk);
    chk("setup_psel_penable", 64'({psel, penable}), 64'(2'b10));
    chk("setup_req_ready", 64'(req_ready), 64'(0));
    chk("setup_paddr", 64'(paddr), 64'(a));
    chk("setup_pwrite", 64'(pwrite), 64'(wr));
    if (wr) chk("setup_pwdata", 64'(pwdata), 64'(d));
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      chk("access_psel_penable", 64'({psel, penable}), 64'(2'b11));
      chk("access_paddr", 64'(paddr), 64'(a));
      chk("access_rsp_valid", 64'(rsp_valid), 64'(0));
      pready = !to && (i == n - 1);
    end
    @(negedge pclk);
    pready = 1'b0;
    chk("done_rsp_valid", 64'(rsp_valid), 64'(oh));
    chk("done_rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    chk("done_rsp_err", 64'(rsp_err), 64'(exp_err));
    chk("done_psel", 64'({psel, penable}), 64'(2'b00));
  endtask

  initial begin
    vecs[0] = '{c: 0, wr: 1'b1, addr: INTEN_OFF, wdata: 32'hFACE,      waits: 0, exp_rdata: 32'h0,      exp_err: 1'b0};
    vecs[1] = '{c: 1, wr: 1'b0, addr: STAT_OFF,  wdata: 32'h0,         waits: 0, exp_rdata: STAT_RST,   exp_err: 1'b0};
    vecs[2] = '{c: 0, wr: 1'b0, addr: INTEN_OFF, wdata: 32'h0,         waits: 0, exp_rdata: INTEN_RST,  exp_err: 1'b0};
    vecs[3] = '{c: 1, wr: 1'b1, addr: CTL_OFF,   wdata: 32'h1234_5678, waits: 0, exp_rdata: 32'h0,      exp_err: 1'b0};
    vecs[4] = '{c: 0, wr: 1'b0, addr: 32'hC,     wdata: 32'h0,         waits: 0, exp_rdata: 32'h0,      exp_err: 1'b1};
    vecs[5] = '{c: 1, wr: 1'b0, addr: STAT_OFF,  wdata: 32'h0,         waits: 3, exp_rdata: STAT_RST,   exp_err: 1'b0};
    vecs[6] = '{c: 0, wr: 1'b0, addr: CTL_OFF,   wdata: 32'h0,         waits: 1, exp_rdata: CTL_RST,    exp_err: 1'b0};

    prstn = 1'b0; pready = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge pclk);
    prstn = 1'b1;
    repeat (2) @(negedge pclk);
    chk("rst_psel", 64'(psel), 64'(0));
    chk("rst_penable", 64'(penable), 64'(0));
    chk("rst_pwrite", 64'(pwrite), 64'(0));
    chk("rst_paddr", 64'(paddr), 64'(0));
    chk("rst_pwdata", 64'(pwdata), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));

    // RR from reset: client0 first, client1 accepted in the completion cycle
    @(posedge pclk); #1;
    set_req(0, 1'b0, CTL_OFF, 32'h0);
    set_req(1, 1'b0, CTL_OFF, 32'h0);
    @(negedge pclk);
    expect_xfer(0, 1'b0, CTL_OFF, 32'h0, 0, 1'b0, CTL_RST, 1'b0);
    expect_xfer(1, 1'b0, CTL_OFF, 32'h0, 0, 1'b0, CTL_RST, 1'b0);
    // ptr now 0: lone client0 moves it to 1, then a tie goes to client1
    @(posedge pclk); #1;
    set_req(0, 1'b0, CTL_OFF, 32'h0);
    @(negedge pclk);
    expect_xfer(0, 1'b0, CTL_OFF, 32'h0, 0, 1'b0, CTL_RST, 1'b0);
    @(posedge pclk); #1;
    set_req(0, 1'b0, INTEN_OFF, 32'h0);
    set_req(1, 1'b0, STAT_OFF, 32'h0);
    @(negedge pclk);
    expect_xfer(1, 1'b0, STAT_OFF, 32'h0, 0, 1'b0, STAT_RST, 1'b0);
    expect_xfer(0, 1'b0, INTEN_OFF, 32'h0, 0, 1'b0, INTEN_RST, 1'b0);

    foreach (vecs[i]) begin
      @(posedge pclk); #1;
      set_req(vecs[i].c, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      @(negedge pclk);
      expect_xfer(vecs[i].c, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
                  1'b0, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // timeout after a successful read so rdata visibly clears
    @(posedge pclk); #1;
    set_req(1, 1'b0, STAT_OFF, 32'h0);
    @(negedge pclk);
    expect_xfer(1, 1'b0, STAT_OFF, 32'h0, 0, 1'b0, STAT_RST, 1'b0);
    @(posedge pclk); #1;
    set_req(1, 1'b0, STAT_OFF, 32'h0);
    @(negedge pclk);
    expect_xfer(1, 1'b0, STAT_OFF, 32'h0, 0, 1'b1, 32'h0, 1'b1);
    @(negedge pclk);
    chk("hold_rsp_err", 64'(rsp_err), 64'(1));
    chk("hold_rsp_valid", 64'(rsp_valid), 64'(0));

    // reset in ACCESS with ptr pointing at client1
    @(posedge pclk); #1;
    set_req(0, 1'b0, STAT_OFF, 32'h0);
    @(negedge pclk);
    chk("pre_rst_ready", 64'(req_ready), 64'(2'b01));
    @(posedge pclk); #1;
    req_valid = '0;
    @(negedge pclk);
    @(negedge pclk);
    chk("pre_rst_access", 64'({psel, penable}), 64'(2'b11));
    #2 prstn = 1'b0;
    #1;
    chk("rst_mid_strobes", 64'({psel, penable}), 64'(2'b00));
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
    @(negedge pclk);
    chk("rst_mid_rsp_valid2", 64'(rsp_valid), 64'(0));
    prstn = 1'b1;
    @(negedge pclk);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("post_rst_psel", 64'(psel), 64'(0));
    @(posedge pclk); #1;
    set_req(0, 1'b1, CTL_OFF, 32'hA5A5_0001);
    set_req(1, 1'b1, INTEN_OFF, 32'h5A5A_0002);
    @(negedge pclk);
    expect_xfer(0, 1'b1, CTL_OFF, 32'hA5A5_0001, 0, 1'b0, 32'h0, 1'b0);
    expect_xfer(1, 1'b1, INTEN_OFF, 32'h5A5A_0002, 0, 1'b0, 32'h0, 1'b0);

    repeat (2) @(negedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
